// File: rtl/uart_pkg.sv
// Shared state encoding, default parameters and sizing helpers for the UART TX arbiter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND      = 2'd1,
      WAIT_ACK  = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   localparam int unsigned NUM_REQ_DEF     = 4;
   localparam int unsigned MAX_BURST_DEF   = 16;
   localparam int unsigned GAP_TIMEOUT_DEF = 1024;
   localparam int unsigned ACK_TIMEOUT_DEF = 4;

   // Counter/index width for a range of n values, never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, modulo N.
module rr_pick #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] j;

   // Scan requesters starting at ptr; the first hit wins.
   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      j      = '0;
      for (int unsigned k = 0; k < N; k++) begin
         j = IW'((32'(ptr) + k) % N);
         if (!any && req[j]) begin
            any       = 1'b1;
            onehot[j] = 1'b1;
            idx       = j;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between byte-stream requesters,
// with per-grant burst limit, stall timeout and transmitter acknowledge timeout.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned NUM_REQ     = NUM_REQ_DEF,
   parameter int unsigned MAX_BURST   = MAX_BURST_DEF,
   parameter int unsigned GAP_TIMEOUT = GAP_TIMEOUT_DEF,
   parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic                 tx_busy,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 err_ack
);

   localparam int unsigned IW = idx_width(NUM_REQ);
   localparam int unsigned BW = $clog2(MAX_BURST + 1);
   localparam int unsigned GW = idx_width(GAP_TIMEOUT);
   localparam int unsigned AW = idx_width(ACK_TIMEOUT);

   state_t          state;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   g_idx;
   logic [BW-1:0]   burst_cnt;
   logic [GW-1:0]   gap_cnt;
   logic [AW-1:0]   ack_cnt;
   logic            last_q;

   logic [NUM_REQ-1:0] pick_onehot;
   logic [IW-1:0]      pick_idx;
   logic               pick_any;
   logic               sel_valid;
   logic               sel_last;
   logic [7:0]         sel_data;
   logic [IW-1:0]      next_ptr;

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req    (req_valid),
      .ptr    (rr_ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   // Offer of the current owner, selected by the one-hot grant.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         sel_data = sel_data | (req_data[8*i +: 8] & {8{grant[i]}});
      end
   end

   assign sel_valid = |(req_valid & grant);
   assign sel_last  = |(req_last & grant);
   assign next_ptr  = (g_idx == IW'(NUM_REQ - 1)) ? '0 : g_idx + IW'(1);

   // Handshake only for the owner, and only while a byte can be taken.
   assign req_ready = (state == SEND) ? (grant & req_valid) : '0;

   // Arbitration FSM with registered grant, launch pulse and error flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         grant     <= '0;
         g_idx     <= '0;
         rr_ptr    <= '0;
         tx_start  <= 1'b0;
         tx_data   <= '0;
         err_ack   <= 1'b0;
         burst_cnt <= '0;
         gap_cnt   <= '0;
         ack_cnt   <= '0;
         last_q    <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         case (state)
            IDLE: begin
               if (!tx_busy && pick_any) begin
                  grant     <= pick_onehot;
                  g_idx     <= pick_idx;
                  burst_cnt <= '0;
                  gap_cnt   <= '0;
                  state     <= SEND;
               end
            end
            SEND: begin
               if (sel_valid) begin
                  tx_data   <= sel_data;
                  tx_start  <= 1'b1;
                  last_q    <= sel_last;
                  burst_cnt <= burst_cnt + BW'(1);
                  ack_cnt   <= '0;
                  state     <= WAIT_ACK;
               end else if (gap_cnt == GW'(GAP_TIMEOUT - 1)) begin
                  grant  <= '0;
                  rr_ptr <= next_ptr;
                  state  <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            WAIT_ACK: begin
               if (tx_busy) begin
                  state <= WAIT_DONE;
               end else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
                  err_ack <= 1'b1;
                  grant   <= '0;
                  rr_ptr  <= next_ptr;
                  state   <= IDLE;
               end else begin
                  ack_cnt <= ack_cnt + AW'(1);
               end
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  if (last_q || (burst_cnt == BW'(MAX_BURST))) begin
                     grant  <= '0;
                     rr_ptr <= next_ptr;
                     state  <= IDLE;
                  end else begin
                     gap_cnt <= '0;
                     state   <= SEND;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued requesters, a simple transmitter model,
// a vector table for first-grant selection and hand sequences for multi-cycle cases.
module tb_uart_tx_arbiter;

   localparam int NR = 4;

   logic            clk;
   logic            reset;
   logic [NR-1:0]   req_valid;
   logic [8*NR-1:0] req_data;
   logic [NR-1:0]   req_last;
   logic [NR-1:0]   req_ready;
   logic            tx_busy;
   logic            tx_start;
   logic [7:0]      tx_data;
   logic [NR-1:0]   grant;
   logic            err_ack;

   uart_tx_arbiter #(
      .NUM_REQ     (4),
      .MAX_BURST   (16),
      .GAP_TIMEOUT (1024),
      .ACK_TIMEOUT (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .tx_busy   (tx_busy),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .grant     (grant),
      .err_ack   (err_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total;
   int bad;

   // Per-requester byte queues.
   logic [7:0]    qd [NR][32];
   logic          ql [NR][32];
   int            qn [NR];
   int            qp [NR];
   logic [NR-1:0] en;

   // Log of launched frames.
   logic [7:0]    log_d [64];
   logic [NR-1:0] log_g [64];
   int            nlog;

   int   busy_left;
   int   busy_len;
   logic no_ack;

   typedef struct packed {
      logic [3:0] valid;
      logic [3:0] g;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input int r, input logic [7:0] d, input logic l);
      if (qn[r] < 32) begin
         qd[r][qn[r]] = d;
         ql[r][qn[r]] = l;
         qn[r]++;
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         if (en[i] && qp[i] < qn[i]) begin
            req_valid[i]       = 1'b1;
            req_data[8*i +: 8] = qd[i][qp[i]];
            req_last[i]        = ql[i][qp[i]];
         end else begin
            req_valid[i]       = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i]        = 1'b0;
         end
      end
   endtask

   // One clock: sample mid-cycle, then update requesters and transmitter after the edge.
   task automatic step();
      logic [NR-1:0] hs;
      logic          st;
      @(negedge clk);
      hs = req_valid & req_ready;
      st = tx_start;
      if (st && nlog < 64) begin
         log_d[nlog] = tx_data;
         log_g[nlog] = grant;
         nlog++;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
         if (hs[i]) qp[i]++;
      end
      if (busy_left > 0) begin
         busy_left--;
         if (busy_left == 0) tx_busy = 1'b0;
      end
      if (st && !no_ack) begin
         tx_busy   = 1'b1;
         busy_left = busy_len;
      end
      drive();
   endtask

   task automatic clear_all();
      for (int i = 0; i < NR; i++) begin
         qn[i] = 0;
         qp[i] = 0;
      end
      nlog      = 0;
      tx_busy   = 1'b0;
      busy_left = 0;
      no_ack    = 1'b0;
      en        = '1;
      drive();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_all();
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic run_until_idle(input string name, input int want, input int budget);
      int n;
      n = 0;
      while (!(nlog >= want && grant == '0 && !tx_busy) && n < budget) begin
         step();
         n++;
      end
      chk({name, "_timeout"}, 32'(n < budget), 32'd1);
   endtask

   initial begin
      int n;
      int cnt;
      logic seen;
      total    = 0;
      bad      = 0;
      busy_len = 40;
      reset    = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      clear_all();
      #12;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_start", 32'(tx_start), 32'd0);
      chk("rst_data", 32'(tx_data), 32'd0);
      chk("rst_err", 32'(err_ack), 32'd0);

      // First grant after reset: pointer at 0, lowest valid index at or after it wins.
      tbl[0] = '{valid: 4'b0001, g: 4'b0001};
      tbl[1] = '{valid: 4'b0110, g: 4'b0010};
      tbl[2] = '{valid: 4'b1100, g: 4'b0100};
      tbl[3] = '{valid: 4'b1000, g: 4'b1000};
      tbl[4] = '{valid: 4'b0000, g: 4'b0000};
      tbl[5] = '{valid: 4'b1111, g: 4'b0001};
      for (int v = 0; v < 6; v++) begin
         do_reset();
         for (int i = 0; i < NR; i++) begin
            if (tbl[v].valid[i]) push(i, 8'(16 + i), 1'b1);
         end
         drive();
         step();
         chk($sformatf("tbl%0d_grant", v), 32'(grant), 32'(tbl[v].g));
         chk($sformatf("tbl%0d_ready", v), 32'(req_ready), 32'(tbl[v].g));
      end

      // Three-byte packet from requester 1.
      do_reset();
      push(1, 8'hA5, 1'b0);
      push(1, 8'h3C, 1'b0);
      push(1, 8'h7E, 1'b1);
      drive();
      run_until_idle("pkt3", 3, 400);
      chk("pkt3_count", 32'(nlog), 32'd3);
      chk("pkt3_d0", 32'(log_d[0]), 32'hA5);
      chk("pkt3_d1", 32'(log_d[1]), 32'h3C);
      chk("pkt3_d2", 32'(log_d[2]), 32'h7E);
      for (int k = 0; k < 3; k++) chk($sformatf("pkt3_g%0d", k), 32'(log_g[k]), 32'b0010);
      chk("pkt3_grant_end", 32'(grant), 32'd0);

      // Requesters 0 and 2 alternate.
      do_reset();
      push(0, 8'h01, 1'b1);
      push(0, 8'h02, 1'b1);
      push(2, 8'h21, 1'b1);
      push(2, 8'h22, 1'b1);
      drive();
      run_until_idle("rr", 4, 600);
      chk("rr_g0", 32'(log_g[0]), 32'b0001);
      chk("rr_g1", 32'(log_g[1]), 32'b0100);
      chk("rr_g2", 32'(log_g[2]), 32'b0001);
      chk("rr_g3", 32'(log_g[3]), 32'b0100);
      chk("rr_d1", 32'(log_d[1]), 32'h21);
      chk("rr_d2", 32'(log_d[2]), 32'h02);

      // Burst limit: 20 bytes from requester 3 with requester 0 waiting.
      do_reset();
      en = 4'b1000;
      for (int k = 0; k < 20; k++) push(3, 8'(8'h30 + k), 1'b0);
      push(0, 8'h0A, 1'b1);
      drive();
      n = 0;
      while (grant != 4'b1000 && n < 10) begin
         step();
         n++;
      end
      chk("burst_first_grant", 32'(grant), 32'b1000);
      en = '1;
      drive();
      run_until_idle("burst", 21, 3500);
      chk("burst_count", 32'(nlog), 32'd21);
      for (int k = 0; k < 21; k++) begin
         if (k < 16) begin
            chk($sformatf("burst_%0d", k), {20'd0, log_g[k], log_d[k]}, {20'd0, 4'b1000, 8'(8'h30 + k)});
         end else if (k == 16) begin
            chk($sformatf("burst_%0d", k), {20'd0, log_g[k], log_d[k]}, {20'd0, 4'b0001, 8'h0A});
         end else begin
            chk($sformatf("burst_%0d", k), {20'd0, log_g[k], log_d[k]}, {20'd0, 4'b1000, 8'(8'h30 + k - 1)});
         end
      end

      // Stall timeout: requester 1 sends one byte then goes quiet.
      do_reset();
      push(1, 8'h55, 1'b0);
      push(2, 8'h66, 1'b1);
      drive();
      n = 0;
      while (nlog < 1 && n < 50) begin
         step();
         n++;
      end
      chk("gap_first_start", 32'(nlog), 32'd1);
      seen = 1'b0;
      cnt  = 0;
      n    = 0;
      while (n < 2000) begin
         step();
         n++;
         if (tx_busy) seen = 1'b1;
         else if (seen) begin
            if (grant == 4'b0010) cnt++;
            else break;
         end
      end
      // One WAIT_DONE cycle plus 1024 stalled SEND cycles with grant held.
      chk("gap_hold_cycles", 32'(cnt), 32'd1025);
      run_until_idle("gap", 2, 200);
      chk("gap_next_grant", 32'(log_g[1]), 32'b0100);
      chk("gap_next_data", 32'(log_d[1]), 32'h66);
      chk("gap_err", 32'(err_ack), 32'd0);

      // Acknowledge timeout: transmitter never goes busy.
      do_reset();
      no_ack = 1'b1;
      push(0, 8'h77, 1'b1);
      drive();
      n = 0;
      while (nlog < 1 && n < 50) begin
         step();
         n++;
      end
      chk("ack_start", 32'(nlog), 32'd1);
      chk("ack_err_t1", 32'(err_ack), 32'd0);
      step();
      step();
      chk("ack_err_t3", 32'(err_ack), 32'd0);
      chk("ack_grant_t3", 32'(grant), 32'b0001);
      step();
      chk("ack_err_t4", 32'(err_ack), 32'd1);
      chk("ack_grant_t4", 32'(grant), 32'd0);
      no_ack = 1'b0;
      push(1, 8'h88, 1'b1);
      drive();
      run_until_idle("ack_next", 2, 300);
      chk("ack_next_data", 32'(log_d[1]), 32'h88);
      chk("ack_next_grant", 32'(log_g[1]), 32'b0010);
      chk("ack_err_sticky", 32'(err_ack), 32'd1);

      // Reset during WAIT_DONE of a three-byte packet.
      do_reset();
      push(0, 8'h0F, 1'b1);
      push(2, 8'hC1, 1'b0);
      push(2, 8'hC2, 1'b0);
      push(2, 8'hC3, 1'b1);
      drive();
      n = 0;
      while (!(nlog >= 2 && tx_busy) && n < 600) begin
         step();
         n++;
      end
      chk("mid_reach", 32'(n < 600), 32'd1);
      for (int k = 0; k < 5; k++) step();
      reset = 1'b1;
      #1;
      chk("mid_rst_grant", 32'(grant), 32'd0);
      chk("mid_rst_start", 32'(tx_start), 32'd0);
      chk("mid_rst_data", 32'(tx_data), 32'd0);
      chk("mid_rst_ready", 32'(req_ready), 32'd0);
      chk("mid_rst_err", 32'(err_ack), 32'd0);
      for (int i = 0; i < NR; i++) begin
         qn[i] = 0;
         qp[i] = 0;
      end
      tx_busy   = 1'b0;
      busy_left = 0;
      drive();
      step();
      step();
      step();
      chk("mid_no_start", 32'(nlog), 32'd2);
      push(0, 8'h01, 1'b1);
      push(1, 8'h02, 1'b1);
      drive();
      reset = 1'b0;
      run_until_idle("mid_after", 4, 400);
      chk("mid_after_g0", 32'(log_g[2]), 32'b0001);
      chk("mid_after_d0", 32'(log_d[2]), 32'h01);
      chk("mid_after_g1", 32'(log_g[3]), 32'b0010);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
